// File: rtl/sram_tester.sv
// Write-then-read-back test sequencer for the byte-wide SRAM controller host port.
// Paces each controller operation with a fixed wait, since the controller has no ack.
module sram_tester #(
   parameter int                ADDR_W    = 19,
   parameter int                DATA_W    = 8,
   parameter logic [ADDR_W-1:0] LAST_ADDR = 19'h7FFFF,
   parameter int                OP_WAIT   = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [1:0]        pattern_sel,
   input  logic [DATA_W-1:0] data_s2f,
   output logic              start_operation,
   output logic              rw,
   output logic [ADDR_W-1:0] address_input,
   output logic [DATA_W-1:0] data_f2s,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       error_count,
   output logic [ADDR_W-1:0] first_fail_addr,
   output logic [DATA_W-1:0] first_fail_data
);

   typedef enum logic [2:0] {
      HOLDOFF, IDLE, W_ISSUE, W_WAIT, R_ISSUE, R_WAIT, R_CHECK, DONE
   } state_t;

   localparam int               CNT_W    = $clog2(OP_WAIT + 1);
   localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(OP_WAIT - 1);
   localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(OP_WAIT - 2);

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [1:0]        sel_reg, sel_next;
   logic [15:0]       err_next;
   logic [DATA_W-1:0] expect_data, issue_data;
   logic              accept, miscompare;

   function automatic logic [DATA_W-1:0] pattern(input logic [1:0] sel,
                                                 input logic [ADDR_W-1:0] a);
      logic [18:0] ax;
      logic [7:0]  p;
      ax = 19'(a);
      case (sel)
         2'd0:    p = ax[7:0];
         2'd1:    p = ~ax[7:0];
         2'd2:    p = ax[0] ? 8'hAA : 8'h55;
         default: p = ax[7:0] ^ ax[15:8] ^ {5'b0, ax[18:16]};
      endcase
      return DATA_W'(p);
   endfunction

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      addr_next   = addr_reg;
      sel_next    = sel_reg;
      accept      = 1'b0;
      expect_data = pattern(sel_reg, addr_reg);
      miscompare  = (state_reg == R_CHECK) && (data_s2f != expect_data);
      err_next    = error_count;
      if (miscompare && (error_count != 16'hFFFF))
         err_next = error_count + 16'd1;

      case (state_reg)
         HOLDOFF: begin
            if (cnt_reg == HOLD_END) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         IDLE, DONE: begin
            if (run) begin
               accept     = 1'b1;
               sel_next   = pattern_sel;
               addr_next  = '0;
               state_next = W_ISSUE;
            end
         end
         W_ISSUE: begin
            state_next = W_WAIT;
            cnt_next   = '0;
         end
         W_WAIT: begin
            if (cnt_reg == WAIT_END) begin
               if (addr_reg == LAST_ADDR) begin
                  addr_next  = '0;
                  state_next = R_ISSUE;
               end else begin
                  addr_next  = addr_reg + 1'b1;
                  state_next = W_ISSUE;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         R_ISSUE: begin
            state_next = R_WAIT;
            cnt_next   = '0;
         end
         R_WAIT: begin
            if (cnt_reg == WAIT_END)
               state_next = R_CHECK;
            else
               cnt_next = cnt_reg + 1'b1;
         end
         R_CHECK: begin
            if (addr_reg == LAST_ADDR) begin
               state_next = DONE;
            end else begin
               addr_next  = addr_reg + 1'b1;
               state_next = R_ISSUE;
            end
         end
         default: state_next = HOLDOFF;
      endcase

      issue_data = pattern(sel_next, addr_next);
   end

   // Outputs are registered from the next state so the strobe coincides with the ISSUE cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= HOLDOFF;
         cnt_reg         <= '0;
         addr_reg        <= '0;
         sel_reg         <= 2'd0;
         start_operation <= 1'b0;
         rw              <= 1'b1;
         address_input   <= '0;
         data_f2s        <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         error_count     <= 16'd0;
         first_fail_addr <= '0;
         first_fail_data <= '0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         addr_reg        <= addr_next;
         sel_reg         <= sel_next;
         start_operation <= (state_next == W_ISSUE) || (state_next == R_ISSUE);
         if (state_next == W_ISSUE) begin
            rw            <= 1'b0;
            address_input <= addr_next;
            data_f2s      <= issue_data;
         end else if (state_next == R_ISSUE) begin
            rw            <= 1'b1;
            address_input <= addr_next;
         end
         busy <= !(state_next inside {HOLDOFF, IDLE, DONE});
         done <= (state_next == DONE);
         pass <= (state_next == DONE) && (err_next == 16'd0);
         if (accept) begin
            error_count     <= 16'd0;
            first_fail_addr <= '0;
            first_fail_data <= '0;
         end else if (miscompare) begin
            error_count <= err_next;
            if (error_count == 16'd0) begin
               first_fail_addr <= addr_reg;
               first_fail_data <= data_s2f;
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_tester.sv
// Bench for sram_tester: behavioural controller+SRAM with a stuck-bit fault, a pass-level
// reference model feeding a scoreboard, and a protocol monitor on the controller port.
module tb_sram_tester;
   localparam int             AW   = 19;
   localparam int             DW   = 8;
   localparam int             OPW  = 6;
   localparam int             N    = 16;
   localparam logic [AW-1:0]  LAST = 19'd15;

   logic           clk = 1'b0;
   logic           reset, run;
   logic [1:0]     pattern_sel;
   logic [DW-1:0]  data_s2f;
   logic           start_operation, rw, busy, done, pass;
   logic [AW-1:0]  address_input, first_fail_addr;
   logic [DW-1:0]  data_f2s, first_fail_data;
   logic [15:0]    error_count;

   sram_tester #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(LAST), .OP_WAIT(OPW)) dut (
      .clk(clk), .reset(reset), .run(run), .pattern_sel(pattern_sel), .data_s2f(data_s2f),
      .start_operation(start_operation), .rw(rw), .address_input(address_input),
      .data_f2s(data_f2s), .busy(busy), .done(done), .pass(pass), .error_count(error_count),
      .first_fail_addr(first_fail_addr), .first_fail_data(first_fail_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rw;
      int         addr;
      logic [7:0] data;
      int         idx;
   } op_t;
   typedef struct {
      int         err;
      int         ffa;
      logic [7:0] ffd;
      logic       pass;
   } fin_t;

   op_t  exp_ops[$];
   fin_t exp_fin[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   logic fault_en = 1'b0;
   int   fault_addr = 0;
   int   fault_bit = 0;
   logic fault_val = 1'b0;

   // Pattern rules written as plain arithmetic on the integer address.
   function automatic logic [7:0] ref_pattern(int sel, int a);
      case (sel)
         0:       return 8'(a % 256);
         1:       return 8'(255 - (a % 256));
         2:       return ((a % 2) == 1) ? 8'hAA : 8'h55;
         default: return 8'((a % 256) ^ ((a / 256) % 256) ^ ((a / 65536) % 8));
      endcase
   endfunction

   function automatic logic [7:0] sram_read(int a, logic [7:0] stored);
      logic [7:0] v;
      v = stored;
      if (fault_en && (a == fault_addr))
         v[fault_bit] = fault_val;
      return v;
   endfunction

   task automatic check(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Controller + async SRAM: latches the request, busy 5 cycles, read data registered.
   logic [7:0]    mem [0:15];
   int            ctrl_cnt;
   logic          op_rw;
   logic [AW-1:0] op_addr;
   logic [7:0]    op_data;

   always @(posedge clk) begin
      if (reset) begin
         ctrl_cnt <= 0;
         data_s2f <= 8'h00;
      end else begin
         if (start_operation) begin
            ctrl_cnt <= 5;
            op_rw    <= rw;
            op_addr  <= address_input;
            op_data  <= data_f2s;
         end else if (ctrl_cnt != 0) begin
            ctrl_cnt <= ctrl_cnt - 1;
         end
         if (ctrl_cnt == 4) begin
            if (op_rw)
               data_s2f <= sram_read(int'(op_addr[3:0]), mem[op_addr[3:0]]);
            else
               mem[op_addr[3:0]] <= op_data;
         end
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: pops expected operations per strobe and expected status per done edge.
   initial begin : monitor
      logic          prev_start, prev_done, stable_ok, last_rw;
      int            last_cyc, first_cyc;
      logic [AW-1:0] last_addr;
      logic [7:0]    last_data;
      op_t           e;
      fin_t          f;
      prev_start = 1'b0; prev_done = 1'b0; stable_ok = 1'b1; last_rw = 1'b1;
      last_cyc = 0; first_cyc = 0; last_addr = '0; last_data = 8'h00;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_start = 1'b0;
            prev_done  = 1'b0;
            stable_ok  = 1'b1;
         end else begin
            if (start_operation) begin
               check("strobe_width", prev_start, 0);
               check("strobe_while_ctrl_busy", ctrl_cnt, 0);
               if (exp_ops.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_strobe: strobe rw=%0d addr=%0h, required none", rw, address_input);
               end else begin
                  e = exp_ops.pop_front();
                  check("op_rw", rw, e.rw);
                  check("op_addr", address_input, e.addr);
                  if (!e.rw)
                     check("op_wdata", data_f2s, e.data);
                  if (e.idx == 0) begin
                     first_cyc = cyc;
                     check("busy_at_first_issue", busy, 1);
                  end else begin
                     check("issue_spacing", cyc - last_cyc, last_rw ? OPW + 1 : OPW);
                     check("held_between_strobes", stable_ok, 1);
                  end
               end
               last_cyc = cyc; last_rw = rw; last_addr = address_input; last_data = data_f2s;
               stable_ok = 1'b1;
            end else if (rw !== last_rw || address_input !== last_addr || data_f2s !== last_data) begin
               stable_ok = 1'b0;
            end

            if (done && !prev_done) begin
               if (exp_fin.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: done rose with no pass outstanding");
               end else begin
                  f = exp_fin.pop_front();
                  check("error_count", error_count, f.err);
                  check("first_fail_addr", first_fail_addr, f.ffa);
                  check("first_fail_data", first_fail_data, f.ffd);
                  check("pass", pass, f.pass);
                  check("busy_at_done", busy, 0);
                  check("issue_to_done_cycles", cyc - first_cyc, N * OPW + N * (OPW + 1));
                  $display("pass done: errors=%0d first_fail_addr=%0d first_fail_data=%02h pass=%0d",
                           error_count, first_fail_addr, first_fail_data, pass);
               end
            end
            prev_start = start_operation;
            prev_done  = done;
         end
      end
   end

   task automatic check_reset_values(string tag);
      check({tag, "_start_operation"}, start_operation, 0);
      check({tag, "_rw"}, rw, 1);
      check({tag, "_address_input"}, address_input, 0);
      check({tag, "_data_f2s"}, data_f2s, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_pass"}, pass, 0);
      check({tag, "_error_count"}, error_count, 0);
      check({tag, "_first_fail_addr"}, first_fail_addr, 0);
      check({tag, "_first_fail_data"}, first_fail_data, 0);
   endtask

   task automatic start_pass(int sel);
      op_t        o;
      fin_t       f;
      int         err;
      int         ffa;
      logic [7:0] ffd;
      logic [7:0] rd;
      err = 0; ffa = 0; ffd = 8'h00;
      pattern_sel = 2'(sel);
      run = 1'b1;
      for (int a = 0; a < N; a++) begin
         o.rw = 1'b0; o.addr = a; o.data = ref_pattern(sel, a); o.idx = a;
         exp_ops.push_back(o);
      end
      for (int a = 0; a < N; a++) begin
         o.rw = 1'b1; o.addr = a; o.data = 8'h00; o.idx = N + a;
         exp_ops.push_back(o);
         rd = sram_read(a, ref_pattern(sel, a));
         if (rd != ref_pattern(sel, a)) begin
            if (err == 0) begin
               ffa = a;
               ffd = rd;
            end
            err++;
         end
      end
      f.err = err; f.ffa = ffa; f.ffd = ffd; f.pass = (err == 0);
      exp_fin.push_back(f);
      $display("run sel=%0d fault_en=%0d fault_addr=%0d bit=%0d val=%0d expect_errors=%0d",
               sel, fault_en, fault_addr, fault_bit, fault_val, err);
      tick();
      run = 1'b0;
   endtask

   task automatic wait_done(string name);
      int n;
      n = 0;
      while (!done && n < 400) begin
         tick();
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: done=0 after %0d cycles, required 1", name, n);
         exp_ops.delete();
         exp_fin.delete();
      end
      tick();
      check({name, "_ops_outstanding"}, exp_ops.size(), 0);
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; pattern_sel = 2'd0;
      repeat (3) tick();
      check_reset_values("in_reset");
      reset = 1'b0;
      tick();
      run = 1'b1;
      tick();
      run = 1'b0;
      repeat (4) begin
         check("holdoff_no_strobe", start_operation, 0);
         check("holdoff_busy", busy, 0);
         tick();
      end
      check_reset_values("after_holdoff");
      repeat (2) tick();

      start_pass(0);
      wait_done("clean_sel0");

      fault_en = 1'b1; fault_addr = 9; fault_bit = 3; fault_val = 1'b0;
      start_pass(0);
      wait_done("stuck_bit");
      check("stuck_error_count", error_count, 1);
      check("stuck_first_fail_addr", first_fail_addr, 9);
      check("stuck_first_fail_data", first_fail_data, 8'h01);
      check("stuck_pass", pass, 0);
      check("stuck_done", done, 1);

      fault_en = 1'b0;
      start_pass(2);
      check("restart_done_cleared", done, 0);
      check("restart_error_count_cleared", error_count, 0);
      check("restart_first_fail_addr_cleared", first_fail_addr, 0);
      check("restart_pass_cleared", pass, 0);
      repeat (50) tick();
      run = 1'b1;
      tick();
      run = 1'b0;
      wait_done("sel2_with_busy_run");

      start_pass(1);
      wait_done("sel1");

      for (int i = 0; i < 4; i++) begin
         fault_en   = 1'($urandom % 2);
         fault_addr = $urandom_range(0, N - 1);
         fault_bit  = $urandom_range(0, 7);
         fault_val  = 1'($urandom % 2);
         start_pass($urandom_range(0, 3));
         wait_done("random");
      end

      fault_en = 1'b0;
      start_pass($urandom_range(0, 3));
      repeat (120) tick();
      reset = 1'b1;
      exp_ops.delete();
      exp_fin.delete();
      tick();
      check_reset_values("mid_reset");
      reset = 1'b0;
      repeat (8) tick();
      start_pass(3);
      wait_done("after_mid_reset");
      check("after_mid_reset_pass", pass, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
